// File: rtl/multu_unit.sv
// rtl/multu_unit.sv - unsigned 32x32 shift-add multiplier with HI/LO result registers
module multu_unit #(
    parameter logic [5:0] MULTU = 6'b011001,
    parameter logic [5:0] MFHI  = 6'b010000,
    parameter logic [5:0] MFLO  = 6'b010010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    input  logic        start,
    output logic [31:0] dataOut,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [31:0] multiplicand;
    logic [63:0] product;
    logic [5:0]  iterCount;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic [32:0] partialSum;
    logic [63:0] nextProduct;

    // Carry out of the upper-half add is kept and shifted back into bit 63.
    always_comb begin
        partialSum  = {1'b0, product[63:32]} + {1'b0, (product[0] ? multiplicand : 32'h0)};
        nextProduct = {partialSum, product[31:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            multiplicand <= 32'h0;
            product      <= 64'h0;
            iterCount    <= 6'd0;
            hiReg        <= 32'h0;
            loReg        <= 32'h0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (Signal == MULTU)) begin
                        multiplicand <= dataA;
                        product      <= {32'h0, dataB};
                        iterCount    <= 6'd0;
                        busy         <= 1'b1;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    // All 32 iterations are complete once the counter reaches 32.
                    if (iterCount == 6'd32) begin
                        hiReg <= product[63:32];
                        loReg <= product[31:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        product   <= nextProduct;
                        iterCount <= iterCount + 6'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dataOut = 32'h0;
        if (Signal == MFHI)
            dataOut = hiReg;
        else if (Signal == MFLO)
            dataOut = loReg;
    end

endmodule

// File: tb/tb_multu_unit.sv
// tb/tb_multu_unit.sv - randomized self-checking bench for multu_unit
module tb_multu_unit;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] ADD   = 6'b100000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dataA = 32'h0;
    logic [31:0] dataB = 32'h0;
    logic [5:0]  Signal = 6'h0;
    logic        start = 1'b0;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] modelHi = 32'h0;
    logic [31:0] modelLo = 32'h0;

    multu_unit #(.MULTU(MULTU), .MFHI(MFHI), .MFLO(MFLO)) dut (
        .clk(clk),
        .reset(reset),
        .dataA(dataA),
        .dataB(dataB),
        .Signal(Signal),
        .start(start),
        .dataOut(dataOut),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutputs(input string tag);
        Signal = MFHI;
        #1;
        checkVal({tag, "_hi"}, {32'h0, dataOut}, {32'h0, modelHi});
        Signal = MFLO;
        #1;
        checkVal({tag, "_lo"}, {32'h0, dataOut}, {32'h0, modelLo});
    endtask

    // One complete multiply; a stray 7x7 start is injected mid-operation and operands are scrambled.
    task automatic runMul(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] expected;
        int lat;
        expected = {32'h0, a} * {32'h0, b};
        dataA  = a;
        dataB  = b;
        Signal = MULTU;
        start  = 1'b1;
        tick();
        checkVal({tag, "_busy_start"}, {63'h0, busy}, 64'h1);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 5) begin
                start  = 1'b1;
                Signal = MULTU;
                dataA  = 32'd7;
                dataB  = 32'd7;
            end else begin
                start  = 1'b0;
                Signal = k[0] ? MFHI : MFLO;
                dataA  = $urandom;
                dataB  = $urandom;
            end
            tick();
            if (done) begin
                lat = k;
                break;
            end
            if (k != 5)
                checkVal({tag, "_hold"}, {32'h0, dataOut}, {32'h0, (k[0] ? modelHi : modelLo)});
            if (k == 16)
                checkVal({tag, "_busy_mid"}, {63'h0, busy}, 64'h1);
        end
        start = 1'b0;
        checkVal({tag, "_latency"}, 64'(lat), 64'd33);
        checkVal({tag, "_busy_done"}, {63'h0, busy}, 64'h0);
        modelHi = expected[63:32];
        modelLo = expected[31:0];
        checkOutputs(tag);
        tick();
        checkVal({tag, "_done_pulse"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        #2;
        reset = 1'b1;
        #1;
        checkVal("rst_busy", {63'h0, busy}, 64'h0);
        checkVal("rst_done", {63'h0, done}, 64'h0);
        checkOutputs("rst");
        tick();
        tick();
        reset = 1'b0;
        tick();

        runMul("basic", 32'd3, 32'd5);
        runMul("max", 32'hFFFFFFFF, 32'hFFFFFFFF);
        runMul("zero", 32'h0, 32'h12345678);

        dataA  = 32'h10000;
        dataB  = 32'h10000;
        Signal = MULTU;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        reset = 1'b1;
        #1;
        checkVal("abort_busy", {63'h0, busy}, 64'h0);
        modelHi = 32'h0;
        modelLo = 32'h0;
        checkOutputs("abort");
        tick();
        reset = 1'b0;
        tick();
        runMul("rerun", 32'h10000, 32'h10000);

        Signal = ADD;
        start  = 1'b1;
        tick();
        checkVal("badcode_busy", {63'h0, busy}, 64'h0);
        start = 1'b0;
        tick();
        checkVal("badcode_busy2", {63'h0, busy}, 64'h0);
        checkVal("mux_add", {32'h0, dataOut}, 64'h0);
        Signal = 6'b000000;
        #1;
        checkVal("mux_other", {32'h0, dataOut}, 64'h0);

        runMul("b2b_first", 32'd6, 32'd7);
        runMul("b2b_second", 32'd2, 32'd2);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i == 0) rb = 32'h0000FFFF & rb;
            runMul("rand", ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
